// File: rtl/calc_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : calc_sequencer                                           |
// | Description : Control FSM for param_loader -> eig_core -> output_loader|
// |               Launches the core, hands its regime to the output loader,|
// |               queues one pending request and counts drops/completions. |
// |               Optional stage-hang abort enabled by SEQ_TIMEOUT_EN.     |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module calc_sequencer #(
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             calc_req,
  input  logic             core_busy,
  input  logic             ol_busy,
  input  logic [2:0]       regime,
  input  logic             clr_err,
  output logic             core_start,
  output logic             start_ol,
  output logic [2:0]       ol_mode,
  output logic             seq_busy,
  output logic             done,
  output logic [CNT_W-1:0] done_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             timeout
);

  localparam logic [2:0] c_ST_IDLE     = 3'd0;
  localparam logic [2:0] c_ST_C_ARM    = 3'd1;
  localparam logic [2:0] c_ST_C_RUN    = 3'd2;
  localparam logic [2:0] c_ST_O_LAUNCH = 3'd3;
  localparam logic [2:0] c_ST_O_ARM    = 3'd4;
  localparam logic [2:0] c_ST_O_RUN    = 3'd5;
  localparam logic [2:0] c_ST_ERR      = 3'd6;

  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic             r_pending;
  logic             w_pending_nxt;
  logic             w_drop;
  logic             w_timer_hit;
  logic             r_core_start;
  logic             r_start_ol;
  logic             w_core_start_nxt;
  logic             w_start_ol_nxt;
  logic             w_done;
  logic [2:0]       r_ol_mode;
  logic [CNT_W-1:0] r_done_cnt;
  logic [CNT_W-1:0] r_drop_cnt;

`ifdef SEQ_TIMEOUT_EN
  localparam int c_TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT_CYC - 1);

  logic [c_TMR_W-1:0] r_timer;
  logic               r_timeout;
  logic               w_wait_state;

  assign w_wait_state = (r_state == c_ST_C_ARM) || (r_state == c_ST_C_RUN) ||
                        (r_state == c_ST_O_ARM) || (r_state == c_ST_O_RUN);
  assign w_timer_hit  = w_wait_state && (r_timer == c_TMR_LAST);

  // Wait-state timer: restarts on every state change, advances only while waiting
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer <= '0;
    end else if (w_state_nxt != r_state) begin
      r_timer <= '0;
    end else if (w_wait_state) begin
      r_timer <= r_timer + c_TMR_W'(1);
    end
  end

  // Sticky abort flag, released only by clr_err while parked in ERR
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timeout <= 1'b0;
    end else if (w_timer_hit) begin
      r_timeout <= 1'b1;
    end else if ((r_state == c_ST_ERR) && clr_err) begin
      r_timeout <= 1'b0;
    end
  end

  assign timeout = r_timeout;
`else
  localparam int c_UNUSED_TMO = TIMEOUT_CYC;
  logic w_unused_clr_err;

  assign w_unused_clr_err = clr_err;
  assign w_timer_hit      = 1'b0;
  assign timeout          = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a queued or simultaneous request relaunches straight from O_RUN
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:     if (calc_req || r_pending) w_state_nxt = c_ST_C_ARM;
      c_ST_C_ARM:    if (core_busy)             w_state_nxt = c_ST_C_RUN;
      c_ST_C_RUN:    if (!core_busy)            w_state_nxt = c_ST_O_LAUNCH;
      c_ST_O_LAUNCH:                            w_state_nxt = c_ST_O_ARM;
      c_ST_O_ARM:    if (ol_busy)               w_state_nxt = c_ST_O_RUN;
      c_ST_O_RUN: begin
        if (!ol_busy) begin
          w_state_nxt = (r_pending || calc_req) ? c_ST_C_ARM : c_ST_IDLE;
        end
      end
`ifdef SEQ_TIMEOUT_EN
      c_ST_ERR:      if (clr_err)               w_state_nxt = c_ST_IDLE;
`endif
      default:                                  w_state_nxt = c_ST_IDLE;
    endcase
    if (w_timer_hit) begin
      w_state_nxt = c_ST_ERR;
    end
  end

  // Output decode: launch pulses are derived from the transition being taken
  always_comb begin
    w_core_start_nxt = (w_state_nxt == c_ST_C_ARM) &&
                       ((r_state == c_ST_IDLE) || (r_state == c_ST_O_RUN));
    w_start_ol_nxt   = (w_state_nxt == c_ST_O_LAUNCH);
    w_done           = (r_state == c_ST_O_RUN) && !ol_busy && !w_timer_hit;
    seq_busy         = (r_state != c_ST_IDLE);
  end

  // Single-entry request queue and drop detection
  always_comb begin
    w_pending_nxt = r_pending;
    w_drop        = 1'b0;
    if (w_timer_hit || (r_state == c_ST_ERR)) begin
      w_pending_nxt = 1'b0;
      w_drop        = calc_req;
    end else if (w_core_start_nxt) begin
      // From O_RUN with a request already queued, a new request takes its slot
      w_pending_nxt = (r_state == c_ST_O_RUN) && r_pending && calc_req;
    end else if (calc_req) begin
      if (r_pending) begin
        w_drop = 1'b1;
      end else begin
        w_pending_nxt = 1'b1;
      end
    end
  end

  // Registered pulses, queue flag, latched regime and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_core_start <= 1'b0;
      r_start_ol   <= 1'b0;
      r_pending    <= 1'b0;
      r_ol_mode    <= 3'd0;
      r_done_cnt   <= '0;
      r_drop_cnt   <= '0;
    end else begin
      r_core_start <= w_core_start_nxt;
      r_start_ol   <= w_start_ol_nxt;
      r_pending    <= w_pending_nxt;
      if ((r_state == c_ST_C_RUN) && (w_state_nxt == c_ST_O_LAUNCH)) begin
        r_ol_mode <= regime;
      end
      if (w_done) begin
        r_done_cnt <= r_done_cnt + CNT_W'(1);
      end
      if (w_drop && (r_drop_cnt != c_CNT_MAX)) begin
        r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      end
    end
  end

  assign core_start = r_core_start;
  assign start_ol   = r_start_ol;
  assign ol_mode    = r_ol_mode;
  assign done       = w_done;
  assign done_cnt   = r_done_cnt;
  assign drop_cnt   = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_calc_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_calc_sequencer                                        |
// | Description : Directed self-checking bench for calc_sequencer          |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module tb_calc_sequencer;

  localparam int CNT_W       = 2;
  localparam int TIMEOUT_CYC = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             calc_req = 1'b0;
  logic             core_busy = 1'b0;
  logic             ol_busy = 1'b0;
  logic [2:0]       regime = 3'd0;
  logic             clr_err = 1'b0;
  logic             core_start;
  logic             start_ol;
  logic [2:0]       ol_mode;
  logic             seq_busy;
  logic             done;
  logic [CNT_W-1:0] done_cnt;
  logic [CNT_W-1:0] drop_cnt;
  logic             timeout;

  int checks = 0;
  int errors = 0;

  calc_sequencer #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .CNT_W      (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .calc_req  (calc_req),
    .core_busy (core_busy),
    .ol_busy   (ol_busy),
    .regime    (regime),
    .clr_err   (clr_err),
    .core_start(core_start),
    .start_ol  (start_ol),
    .ol_mode   (ol_mode),
    .seq_busy  (seq_busy),
    .done      (done),
    .done_cnt  (done_cnt),
    .drop_cnt  (drop_cnt),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  // Advance into the next cycle and drive its handshake inputs
  task automatic step(input logic req, input logic cb, input logic ob);
    @(posedge clk);
    #1;
    calc_req  = req;
    core_busy = cb;
    ol_busy   = ob;
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  // One minimal transaction: req, core busy on entry, one ol_busy cycle
  task automatic txn(input logic [7:0] done_before);
    for (int j = 0; j < 6; j++) begin
      step(j == 0, j == 1, j == 4);
      check("txn_core_start", 8'(core_start), 8'(j == 1));
      check("txn_start_ol", 8'(start_ol), 8'(j == 3));
      check("txn_done", 8'(done), 8'(j == 5));
      check("txn_done_cnt", 8'(done_cnt), done_before);
    end
  endtask

  initial begin
    repeat (3) step(1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Reset state
    check("rst_core_start", 8'(core_start), 8'd0);
    check("rst_start_ol", 8'(start_ol), 8'd0);
    check("rst_ol_mode", 8'(ol_mode), 8'd0);
    check("rst_seq_busy", 8'(seq_busy), 8'd0);
    check("rst_done", 8'(done), 8'd0);
    check("rst_done_cnt", 8'(done_cnt), 8'd0);
    check("rst_drop_cnt", 8'(drop_cnt), 8'd0);
    check("rst_timeout", 8'(timeout), 8'd0);

    // Basic run with regime capture: req@10, core 12..20, ol 23..40
    for (int t = 1; t <= 45; t++) begin
      step(t == 10, (t >= 12) && (t <= 20), (t >= 23) && (t <= 40));
      regime = (t == 21) ? 3'b101 : 3'b000;
      check("b_core_start", 8'(core_start), 8'(t == 11));
      check("b_start_ol", 8'(start_ol), 8'(t == 22));
      check("b_done", 8'(done), 8'(t == 41));
      check("b_seq_busy", 8'(seq_busy), 8'((t >= 11) && (t <= 41)));
      check("b_done_cnt", 8'(done_cnt), (t >= 42) ? 8'd1 : 8'd0);
      check("b_ol_mode", 8'(ol_mode), (t >= 22) ? 8'd5 : 8'd0);
    end

    // Queue: req in C_RUN becomes pending, two reqs in O_RUN are dropped
    for (int t = 1; t <= 28; t++) begin
      step((t == 1) || (t == 5) || (t == 11) || (t == 13),
           ((t >= 3) && (t <= 6)) || ((t >= 18) && (t <= 19)),
           ((t >= 9) && (t <= 14)) || ((t >= 22) && (t <= 23)));
      regime = (t == 7) ? 3'd6 : ((t == 20) ? 3'd2 : 3'd0);
      check("q_core_start", 8'(core_start), 8'((t == 2) || (t == 16)));
      check("q_start_ol", 8'(start_ol), 8'((t == 8) || (t == 21)));
      check("q_done", 8'(done), 8'((t == 15) || (t == 24)));
      check("q_seq_busy", 8'(seq_busy), 8'((t >= 2) && (t <= 24)));
      check("q_drop_cnt", 8'(drop_cnt), (t >= 14) ? 8'd2 : ((t >= 12) ? 8'd1 : 8'd0));
      check("q_done_cnt", 8'(done_cnt), (t >= 25) ? 8'd3 : ((t >= 16) ? 8'd2 : 8'd1));
      check("q_ol_mode", 8'(ol_mode), (t >= 21) ? 8'd2 : ((t >= 8) ? 8'd6 : 8'd5));
    end

    // Saturation and stuck core: one pending, five drops, core never rises
    do_reset();
    for (int t = 1; t <= 20; t++) begin
      step((t <= 13) && (t % 2 == 1) || (t == 19), 1'b0, 1'b0);
      clr_err = (t == 20);
      check("s_core_start", 8'(core_start), 8'(t == 2));
      check("s_seq_busy", 8'(seq_busy), 8'(t >= 2));
      check("s_drop_cnt", 8'(drop_cnt),
            (t >= 10) ? 8'd3 : ((t >= 8) ? 8'd2 : ((t >= 6) ? 8'd1 : 8'd0)));
`ifdef SEQ_TIMEOUT_EN
      check("s_timeout", 8'(timeout), 8'(t >= 18));
`else
      check("s_timeout", 8'(timeout), 8'd0);
`endif
    end
`ifdef SEQ_TIMEOUT_EN
    // After clr_err: IDLE, flag released, queued request discarded
    for (int t = 21; t <= 23; t++) begin
      step(1'b0, 1'b0, 1'b0);
      clr_err = 1'b0;
      check("e_timeout", 8'(timeout), 8'd0);
      check("e_seq_busy", 8'(seq_busy), 8'd0);
      check("e_core_start", 8'(core_start), 8'd0);
    end
    txn(8'd0);
    step(1'b0, 1'b0, 1'b0);
    check("e_done_cnt", 8'(done_cnt), 8'd1);
`else
    clr_err = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    check("s_still_busy", 8'(seq_busy), 8'd1);
`endif

    // done_cnt wraps 3 -> 0 on the 4th completion
    do_reset();
    for (int k = 0; k < 5; k++) begin
      txn(8'(k % 4));
    end
    step(1'b0, 1'b0, 1'b0);
    check("w_done_cnt", 8'(done_cnt), 8'd1);

    // Reset in O_RUN with a pending request and a drop on record
    for (int t = 0; t <= 8; t++) begin
      step((t == 0) || (t >= 6), t == 1, t >= 4);
      if (t == 8) begin
        check("r_pre_drop", 8'(drop_cnt), 8'd1);
        check("r_pre_busy", 8'(seq_busy), 8'd1);
        rst = 1'b1;
      end
    end
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    check("r_core_start", 8'(core_start), 8'd0);
    check("r_start_ol", 8'(start_ol), 8'd0);
    check("r_ol_mode", 8'(ol_mode), 8'd0);
    check("r_seq_busy", 8'(seq_busy), 8'd0);
    check("r_done", 8'(done), 8'd0);
    check("r_done_cnt", 8'(done_cnt), 8'd0);
    check("r_drop_cnt", 8'(drop_cnt), 8'd0);
    check("r_timeout", 8'(timeout), 8'd0);
    for (int t = 0; t < 3; t++) begin
      step(1'b0, 1'b0, 1'b0);
      check("r_no_launch", 8'(core_start), 8'd0);
      check("r_idle", 8'(seq_busy), 8'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
